// File: rtl/exp_unit_pkg.sv
// Shared constants for the Q16.16 exponential unit: format widths, range-reduction
// and polynomial coefficients, clamp limits and saturation value.
package exp_unit_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;
    localparam int X_W    = 49;   // headroom for {Xi,16'b0} - lnF without wrap

    localparam logic signed [31:0] LOG2E = 32'sh0001_7154;
    localparam logic        [15:0] C1    = 16'd43024;
    localparam logic        [15:0] C2    = 16'd22512;

    localparam logic signed [31:0] CLAMP_HI = 32'sh0020_0000;   // +32.0
    localparam logic signed [31:0] CLAMP_LO = -32'sh0020_0000;  // -32.0

    localparam logic signed [15:0] K_SAT = 16'sd16;
    localparam logic signed [15:0] K_UF  = -16'sd17;

    localparam logic [DATA_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

endpackage

// File: rtl/exp_unit_pow2_frac.sv
// Quadratic approximation of 2^f for f in [0,1): m = 1 + C1*f + C2*f^2, result Q1.16.
module pow2_frac
    import exp_unit_pkg::*;
(
    input  logic [15:0] f_i,
    output logic [16:0] m_o
);

    logic [31:0] f_sq;
    logic [31:0] t1;
    logic [31:0] t2;
    logic        unused_lsbs;

    always_comb begin
        f_sq = 32'(f_i) * 32'(f_i);
        t1   = 32'(C1) * 32'(f_i);
        t2   = 32'(C2) * 32'(f_sq[31:16]);
        m_o  = 17'h1_0000 + 17'(t1[31:16]) + 17'(t2[31:16]);
    end

    assign unused_lsbs = ^{f_sq[15:0], t1[15:0], t2[15:0]};

endmodule

// File: rtl/exp_unit.sv
// Three-stage Q16.16 exponential: mode mux + clamp, base-2 range reduction,
// then 2^f polynomial and barrel shift by the integer exponent.
module exp_unit
    import exp_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              is_stage2,
    input  logic              is_stage4,
    input  logic [DATA_W-1:0] lnF,
    input  logic [DATA_W-1:0] Xi,
    output logic [DATA_W-1:0] exp_out
);

    logic                     en;
    logic signed [X_W-1:0]    xi_ext;
    logic signed [X_W-1:0]    lnf_ext;
    logic signed [X_W-1:0]    x_wide;
    logic signed [DATA_W-1:0] x_d, x_q;
    logic signed [63:0]       prod;
    logic signed [15:0]       k_d, k_q;
    logic        [15:0]       f_d, f_q;
    logic        [16:0]       m;
    logic        [15:0]       neg_k;
    logic        [DATA_W-1:0] m_ext;
    logic        [DATA_W-1:0] exp_d, exp_q;
    logic                     unused_bits;

    assign en = is_stage2 | is_stage4;

    // S1: stage 4 wins when both flags are set
    always_comb begin
        xi_ext  = X_W'($signed({Xi, {FRAC_W{1'b0}}}));
        lnf_ext = X_W'($signed(lnF));
        x_wide  = is_stage4 ? (xi_ext - lnf_ext) : xi_ext;
        if (x_wide > X_W'(CLAMP_HI)) begin
            x_d = CLAMP_HI;
        end else if (x_wide < X_W'(CLAMP_LO)) begin
            x_d = CLAMP_LO;
        end else begin
            x_d = x_wide[DATA_W-1:0];
        end
    end

    // S2: y = floor(x * log2(e)); the slice of the product is y's integer and fraction
    always_comb begin
        prod = 64'(x_q) * 64'(LOG2E);
        k_d  = prod[47:32];
        f_d  = prod[31:16];
    end

    pow2_frac u_pow2_frac (
        .f_i (f_q),
        .m_o (m)
    );

    always_comb begin
        neg_k = -k_q;
        m_ext = {{(DATA_W-17){1'b0}}, m};
        if (k_q >= K_SAT) begin
            exp_d = SAT_VAL;
        end else if (k_q <= K_UF) begin
            exp_d = '0;
        end else if (!k_q[15]) begin
            exp_d = m_ext << k_q[3:0];
        end else begin
            exp_d = m_ext >> neg_k[4:0];
        end
    end

    assign unused_bits = ^{prod[63:48], prod[15:0], neg_k[15:5]};

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            k_q   <= '0;
            f_q   <= '0;
            exp_q <= '0;
        end else if (en) begin
            x_q   <= x_d;
            k_q   <= k_d;
            f_q   <= f_d;
            exp_q <= exp_d;
        end
    end

    assign exp_out = exp_q;

endmodule

// File: tb/tb_exp_unit.sv
// Directed + random bench for exp_unit, checked against a real-arithmetic exp() model.
module tb_exp_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        is_stage2 = 1'b0;
    logic        is_stage4 = 1'b0;
    logic [31:0] lnF = '0;
    logic [31:0] Xi = '0;
    logic [31:0] exp_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          valid;
        bit          exact;
        logic [31:0] exact_val;
        real         ref_v;
        string       tag;
    } exp_t;

    exp_t        pipe_q[$];
    logic [31:0] last_out = '0;
    logic [31:0] prev;

    exp_unit dut (
        .clk       (clk),
        .rst       (rst),
        .is_stage2 (is_stage2),
        .is_stage4 (is_stage4),
        .lnF       (lnF),
        .Xi        (Xi),
        .exp_out   (exp_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input bit s4, input int xi, input int lnf, input string tag);
        exp_t e;
        real  x, y, v;
        x = real'(xi);
        if (s4) x = x - real'(lnf) / 65536.0;
        if (x > 32.0)  x = 32.0;
        if (x < -32.0) x = -32.0;
        y = x * 1.4426950408889634;
        v = $exp(x) * 65536.0;
        e.valid = 1'b1;
        e.tag   = tag;
        e.ref_v = v;
        e.exact = 1'b1;
        if (v >= 4294967296.0)  e.exact_val = 32'hFFFF_FFFF;
        else if (y <= -17.0)    e.exact_val = 32'h0;
        else if (x == 0.0)      e.exact_val = 32'h0001_0000;
        else                    e.exact = 1'b0;
        return e;
    endfunction

    task automatic check_entry(input exp_t e);
        real got, tol;
        bit  ok;
        if (e.valid) begin
            vectors++;
            if (e.exact) begin
                assert (exp_out === e.exact_val) else begin
                    miscompares++;
                    $error("FAIL %s: exp_out=%08h expected=%08h", e.tag, exp_out, e.exact_val);
                end
            end else begin
                got = real'(exp_out);
                tol = (0.005 * e.ref_v > 2.0) ? 0.005 * e.ref_v : 2.0;
                ok  = (got - e.ref_v <= tol) && (e.ref_v - got <= tol);
                assert (ok) else begin
                    miscompares++;
                    $error("FAIL %s: exp_out=%08h (%0f) expected~%0f tol=%0f",
                           e.tag, exp_out, got, e.ref_v, tol);
                end
            end
        end
    endtask

    task automatic step(input bit s2, input bit s4, input int xi, input int lnf, input string tag);
        @(negedge clk);
        is_stage2 = s2;
        is_stage4 = s4;
        Xi        = xi;
        lnF       = lnf;
        @(posedge clk);
        #1;
        if (s2 | s4) begin
            pipe_q.push_back(model(s4, xi, lnf, tag));
            if (pipe_q.size() >= 3) check_entry(pipe_q.pop_front());
        end else begin
            vectors++;
            assert (exp_out === last_out) else begin
                miscompares++;
                $error("FAIL stall_hold(%s): exp_out=%08h expected=%08h", tag, exp_out, last_out);
            end
        end
        last_out = exp_out;
    endtask

    task automatic do_reset(input bit s2, input int xi);
        exp_t blank;
        @(negedge clk);
        rst       = 1'b1;
        is_stage2 = s2;
        is_stage4 = 1'b0;
        Xi        = xi;
        lnF       = '0;
        @(posedge clk);
        #1;
        vectors++;
        assert (exp_out === 32'h0) else begin
            miscompares++;
            $error("FAIL reset: exp_out=%08h expected=00000000", exp_out);
        end
        rst = 1'b0;
        last_out = exp_out;
        pipe_q.delete();
        blank.valid = 1'b0;
        blank.exact = 1'b0;
        blank.exact_val = '0;
        blank.ref_v = 0.0;
        blank.tag = "post_reset";
        pipe_q.push_back(blank);
        pipe_q.push_back(blank);
    endtask

    initial begin
        int r, xi, lnf;

        do_reset(1'b0, 0);

        step(1, 0, 0, 0, "s2_unity");
        step(1, 0, 1, 0, "s2_e");
        for (int i = 0; i < 5; i++) step(0, 1, 5, 32'h0000_0A00, "s4_normal");
        prev = exp_out;
        step(0, 1, 5, 32'h0000_0A00, "s4_normal");
        vectors++;
        assert (exp_out === prev) else begin
            miscompares++;
            $error("FAIL s4_stable: exp_out=%08h expected=%08h", exp_out, prev);
        end
        step(0, 1, 0, 32'h000A_0000, "s4_small");
        step(1, 0, 12, 0, "s2_sat");
        step(1, 0, -20, 0, "s2_uflow");
        step(1, 1, 5, 32'h0005_0000, "both_prio");
        step(1, 0, 40000, 0, "s2_clamp_hi");
        step(1, 0, -40000, 0, "s2_clamp_lo");

        // back-to-back with a 2-cycle stall mid-stream
        step(1, 0, 0, 0, "stall_x0");
        step(1, 0, 1, 0, "stall_x1");
        step(0, 0, 7, 0, "stall_a");
        step(0, 0, -9, 32'h1234, "stall_b");
        step(1, 0, 2, 0, "stall_x2");
        step(1, 0, 0, 0, "flush");
        step(1, 0, 0, 0, "flush");

        // reset in mid-stream with enable active
        step(1, 0, 3, 0, "pre_rst");
        do_reset(1'b1, 4);
        step(1, 0, 2, 0, "post_rst_x2");
        step(1, 0, -3, 0, "post_rst_xm3");
        step(1, 0, 1, 0, "post_rst_x1");

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(5, 0));
            case (r)
                0: step(0, 0, int'($urandom), int'($urandom), "rnd_stall");
                1: begin
                    xi = int'($urandom_range(51, 0)) - 40;
                    step(1, 0, xi, int'($urandom), "rnd_s2");
                end
                2: begin
                    xi  = int'($urandom_range(44, 0)) - 33;
                    lnf = int'($urandom_range(65535, 0));
                    step(0, 1, xi, lnf, "rnd_s4");
                end
                3: begin
                    xi  = int'($urandom_range(44, 0)) - 33;
                    lnf = int'($urandom_range(65535, 0));
                    step(1, 1, xi, lnf, "rnd_both");
                end
                4: begin
                    xi = int'($urandom_range(100000, 12));
                    step(1, 0, xi, 0, "rnd_sat");
                end
                default: begin
                    xi = -int'($urandom_range(100000, 33));
                    step(1, 0, xi, 0, "rnd_uflow");
                end
            endcase
        end
        step(1, 0, 0, 0, "flush");
        step(1, 0, 0, 0, "flush");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
